stream_mux_n: RTL and testbench
===============================

// Module: stream_mux_n
// PURPOSE
//  Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshake.
//  Selects one input channel per cycle and holds it in a single output register stage.
//  Channel selection comes from an external select port (MODE=0) or a round-robin arbiter (MODE=1).
//  Sits between multiple producer streams and one shared consumer; successor of the 4:1 bit mux.
// PARAMETERS
//  N     4   number of input channels, 2..16
//  W     8   data width per channel, >=1
//  MODE  0   0 = external select on sel; 1 = internal round-robin
//  SW    localparam = max(1,$clog2(N)), width of sel/out_ch
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     synchronous reset, active-high
//  in_data    in   N*W   channel i occupies bits [i*W +: W]
//  in_valid   in   N     per-channel valid
//  in_last    in   N     per-channel end-of-packet flag
//  in_ready   out  N     per-channel ready (combinational)
//  sel        in   SW    channel select, used only when MODE=0
//  out_data   out  W     registered data
//  out_valid  out  1     registered valid
//  out_last   out  1     registered last of the held beat
//  out_ch     out  SW    registered source channel of the held beat
//  out_ready  in   1     consumer ready
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_last=0, out_ch=0, rr_ptr=0, lock cleared.
//    Reset mid-operation discards the held beat; no in_ready asserted while rst=1.
//  - load_en = rst==0 && (out_valid==0 || out_ready==1). Transfer out when out_valid && out_ready.
//  - Grant (combinational): MODE=0 -> g=sel, valid only if sel<N and in_valid[sel]; sel>=N gives no grant.
//    MODE=1 -> first i with in_valid[i], searching rr_ptr, rr_ptr+1, ... wrapping N-1 -> 0.
//  - in_ready[i] = load_en && grant_valid && (i==g); at most one bit of in_ready is high.
//  - On edge with load_en: if grant_valid, out_* <= channel g beat, out_ch<=g, out_valid<=1;
//    else out_valid<=0 (out_data/out_last/out_ch hold their previous values).
//  - rr_ptr updates only on an accepted beat: rr_ptr <= (g==N-1) ? 0 : g+1.
//  - Latency 1 cycle input->output; full throughput 1 beat/cycle when out_ready held high.
//  - Backpressure: out_valid=1 && out_ready=0 -> out_* held stable, all in_ready=0.
//  - sel changes while a beat is held do not affect out_*; they only affect the next grant.
//  - in_valid dropping without handshake is tolerated: no grant, no state change.
// CONFIGURATION
//  MUX_PKT_LOCK_EN defined: after accepting a beat from channel g with in_last[g]=0, lock to g;
//    grant is forced to g (sel ignored, rr search bypassed, rr_ptr frozen) until a beat with
//    in_last[g]=1 is accepted, then unlock and set rr_ptr=g+1 (wrapped). While locked, an invalid
//    in_valid[g] gives no grant even if other channels are valid. rst clears the lock.
//  MUX_PKT_LOCK_EN undefined: per-beat arbitration; in_last only forwarded to out_last.
// TESTING
//  1 rst=1 for 2 cycles, all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0.
//  2 N=4,W=8,MODE=0: sel=2, in_valid=4'hF, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100;
//    next cycle out_valid=1, out_data=8'hA5, out_ch=2.
//  3 Hold out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_ch unchanged, in_ready=0;
//    raise out_ready -> next beat appears 1 cycle later, none dropped or duplicated.
//  4 MODE=1, all valid, out_ready=1 -> out_ch = 0,1,2,3,0,1; only ch1,ch3 valid -> 1,3,1,3.
//  5 N=3, MODE=0, sel=3, in_valid=3'b111 -> in_ready=0, out_valid stays 0.
//  6 MODE=1, ch0 3-beat packet (last on beat 3), ch1 valid throughout -> with MUX_PKT_LOCK_EN
//    out_ch = 0,0,0,1; without it out_ch = 0,1,0,1,0.

Source files
------------

// File: rtl/stream_mux_n.sv
// N-channel registered stream multiplexer with valid/ready handshake, external-select or round-robin grant.
// Optional packet lock (a started packet keeps its channel until its last beat) enabled by MUX_PKT_LOCK_EN.
module stream_mux_n #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = 0,
    localparam int SW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    output logic            out_last,
    output logic [SW-1:0]   out_ch,
    input  logic            out_ready
);

    localparam int unsigned NU = N;

    logic          load_en;
    logic          accept;
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] ext_g;
    logic          ext_v;
    logic [SW-1:0] rr_g;
    logic          rr_v;
    logic [SW-1:0] g;
    logic          grant_valid;
    logic [SW-1:0] g_next;
    logic [W-1:0]  g_data;
    logic          g_last;

`ifdef MUX_PKT_LOCK_EN
    typedef enum logic {LK_FREE, LK_HELD} lock_t;
    lock_t         lock_state;
    logic [SW-1:0] lock_ch;
    logic          lock_v;

    always_comb begin
        lock_v = 1'b0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (lock_ch == SW'(i)) lock_v = in_valid[i];
        end
    end
`endif

    assign load_en = !rst && (!out_valid || out_ready);
    assign accept  = load_en && grant_valid;
    assign g_next  = (g == SW'(NU - 1)) ? '0 : g + SW'(1);

    // Out-of-range sel never matches a channel, so it simply yields no grant.
    always_comb begin
        ext_g = sel;
        ext_v = 1'b0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (sel == SW'(i)) ext_v = in_valid[i];
        end
    end

    // Round-robin: the valid channel at the smallest wrapped distance from rr_ptr wins.
    always_comb begin
        int unsigned p;
        int unsigned d;
        int unsigned best;
        p    = 32'(rr_ptr);
        d    = 0;
        best = NU;
        rr_g = '0;
        rr_v = 1'b0;
        for (int unsigned i = 0; i < NU; i++) begin
            d = (i >= p) ? (i - p) : (i + NU - p);
            if (in_valid[i] && (d < best)) begin
                best = d;
                rr_g = SW'(i);
                rr_v = 1'b1;
            end
        end
    end

    always_comb begin
        if (MODE == 1) begin
            g           = rr_g;
            grant_valid = rr_v;
        end else begin
            g           = ext_g;
            grant_valid = ext_v;
        end
`ifdef MUX_PKT_LOCK_EN
        if (lock_state == LK_HELD) begin
            g           = lock_ch;
            grant_valid = lock_v;
        end
`endif
    end

    always_comb begin
        g_data = '0;
        g_last = 1'b0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (g == SW'(i)) begin
                g_data = in_data[i*W +: W];
                g_last = in_last[i];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            in_ready[i] = accept && (g == SW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_ch     <= '0;
            rr_ptr     <= '0;
`ifdef MUX_PKT_LOCK_EN
            lock_state <= LK_FREE;
            lock_ch    <= '0;
`endif
        end else if (load_en) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_data <= g_data;
                out_last <= g_last;
                out_ch   <= g;
`ifdef MUX_PKT_LOCK_EN
                // rr_ptr stays frozen for the body of a locked packet.
                if (lock_state == LK_HELD) begin
                    if (g_last) begin
                        lock_state <= LK_FREE;
                        rr_ptr     <= g_next;
                    end
                end else begin
                    rr_ptr <= g_next;
                    if (!g_last) begin
                        lock_state <= LK_HELD;
                        lock_ch    <= g;
                    end
                end
`else
                rr_ptr <= g_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: three instances (N=4 sel, N=4 round-robin, N=3 sel) against a cycle reference model.
// Expectations follow MUX_PKT_LOCK_EN when it is defined for the build.
module tb_stream_mux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] t_data [3];
    logic [3:0]  t_valid[3];
    logic [3:0]  t_last [3];
    logic [1:0]  t_sel  [3];
    logic        t_ordy [3];

    logic [3:0]  rdy[3];
    logic [3:0]  rdy0, rdy1;
    logic [2:0]  rdy2;
    logic [7:0]  od [3];
    logic        ov [3];
    logic        ol [3];
    logic [1:0]  oc [3];

    assign rdy[0] = rdy0;
    assign rdy[1] = rdy1;
    assign rdy[2] = {1'b0, rdy2};

    stream_mux_n #(.N(4), .W(8), .MODE(0)) u_dut_sel (
        .clk(clk), .rst(rst), .in_data(t_data[0]), .in_valid(t_valid[0]), .in_last(t_last[0]),
        .in_ready(rdy0), .sel(t_sel[0]), .out_data(od[0]), .out_valid(ov[0]), .out_last(ol[0]),
        .out_ch(oc[0]), .out_ready(t_ordy[0])
    );

    stream_mux_n #(.N(4), .W(8), .MODE(1)) u_dut_rr (
        .clk(clk), .rst(rst), .in_data(t_data[1]), .in_valid(t_valid[1]), .in_last(t_last[1]),
        .in_ready(rdy1), .sel(t_sel[1]), .out_data(od[1]), .out_valid(ov[1]), .out_last(ol[1]),
        .out_ch(oc[1]), .out_ready(t_ordy[1])
    );

    stream_mux_n #(.N(3), .W(8), .MODE(0)) u_dut_n3 (
        .clk(clk), .rst(rst), .in_data(t_data[2][23:0]), .in_valid(t_valid[2][2:0]),
        .in_last(t_last[2][2:0]), .in_ready(rdy2), .sel(t_sel[2]), .out_data(od[2]),
        .out_valid(ov[2]), .out_last(ol[2]), .out_ch(oc[2]), .out_ready(t_ordy[2])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the held output beat, the round-robin pointer and the packet lock per instance.
    int       m_n   [3] = '{4, 4, 3};
    int       m_mode[3] = '{0, 1, 0};
    bit       m_valid[3];
    bit [7:0] m_data[3];
    bit       m_last[3];
    int       m_ch  [3];
    int       m_ptr [3];
    bit       m_lock[3];
    int       m_lch [3];
    int       eg    [3];
    bit       egv   [3];
    bit       eload [3];
    logic [3:0] rdy_s[3];

    function automatic void predict(int k);
        eload[k] = !rst && (!m_valid[k] || t_ordy[k]);
        eg[k]    = 0;
        egv[k]   = 1'b0;
        if (m_lock[k]) begin
            eg[k]  = m_lch[k];
            egv[k] = t_valid[k][m_lch[k]];
        end else if (m_mode[k] == 0) begin
            if (int'(t_sel[k]) < m_n[k]) begin
                eg[k]  = int'(t_sel[k]);
                egv[k] = t_valid[k][t_sel[k]];
            end
        end else begin
            for (int off = 0; off < m_n[k]; off++) begin
                int c;
                c = (m_ptr[k] + off) % m_n[k];
                if (!egv[k] && t_valid[k][c]) begin
                    eg[k]  = c;
                    egv[k] = 1'b1;
                end
            end
        end
    endfunction

    function automatic void commit(int k);
        if (rst) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
            m_last[k]  = 1'b0;
            m_ch[k]    = 0;
            m_ptr[k]   = 0;
            m_lock[k]  = 1'b0;
        end else if (eload[k]) begin
            if (egv[k]) begin
                m_valid[k] = 1'b1;
                m_data[k]  = t_data[k][eg[k]*8 +: 8];
                m_last[k]  = t_last[k][eg[k]];
                m_ch[k]    = eg[k];
`ifdef MUX_PKT_LOCK_EN
                if (m_lock[k]) begin
                    if (m_last[k]) begin
                        m_lock[k] = 1'b0;
                        m_ptr[k]  = (eg[k] + 1) % m_n[k];
                    end
                end else begin
                    m_ptr[k] = (eg[k] + 1) % m_n[k];
                    if (!m_last[k]) begin
                        m_lock[k] = 1'b1;
                        m_lch[k]  = eg[k];
                    end
                end
`else
                m_ptr[k] = (eg[k] + 1) % m_n[k];
`endif
            end else begin
                m_valid[k] = 1'b0;
            end
        end
    endfunction

    task automatic step();
        #1;
        for (int k = 0; k < 3; k++) begin
            predict(k);
            rdy_s[k] = rdy[k];
            check($sformatf("in_ready[d%0d]", k), 32'(rdy[k]),
                  (eload[k] && egv[k]) ? (32'd1 << eg[k]) : 32'd0);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) commit(k);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("out_valid[d%0d]", k), 32'(ov[k]), 32'(m_valid[k]));
            check($sformatf("out_data[d%0d]", k),  32'(od[k]), 32'(m_data[k]));
            check($sformatf("out_last[d%0d]", k),  32'(ol[k]), 32'(m_last[k]));
            check($sformatf("out_ch[d%0d]", k),    32'(oc[k]), 32'(m_ch[k]));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int exp4a[6] = '{0, 1, 2, 3, 0, 1};
    int exp4b[4] = '{1, 3, 1, 3};
`ifdef MUX_PKT_LOCK_EN
    int exp6[5] = '{0, 0, 0, 1, 1};
`else
    int exp6[5] = '{0, 1, 0, 1, 0};
`endif

    initial begin
        int cnt;
        int nb;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            t_data[k]  = 32'h4433_2211;
            t_valid[k] = 4'hF;
            t_last[k]  = 4'hF;
            t_sel[k]   = 2'd0;
            t_ordy[k]  = 1'b1;
        end

        // Reset with every channel valid.
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_valid[d%0d]", k), 32'(ov[k]), 32'd0);
            check($sformatf("rst_ch[d%0d]", k), 32'(oc[k]), 32'd0);
        end
        rst = 1'b0;

        // External select of channel 2.
        t_sel[0]  = 2'd2;
        t_data[0] = 32'h33A5_1100;
        step();
        check("sel2_ready", 32'(rdy_s[0]), 32'h4);
        check("sel2_data", 32'(od[0]), 32'hA5);
        check("sel2_ch", 32'(oc[0]), 32'd2);

        // Backpressure for three cycles, then release.
        t_ordy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            t_data[0] = $urandom;
            t_sel[0]  = 2'(i);
            step();
            check("bp_ready", 32'(rdy_s[0]), 32'd0);
            check("bp_data", 32'(od[0]), 32'hA5);
        end
        t_ordy[0] = 1'b1;
        t_data[0] = 32'h0000_5A00;
        t_sel[0]  = 2'd1;
        step();
        check("bp_release_data", 32'(od[0]), 32'h5A);

        // sel beyond N-1 on the 3-channel instance.
        t_sel[2]   = 2'd3;
        t_valid[2] = 4'h7;
        for (int i = 0; i < 3; i++) begin
            step();
            check("sel_oor_ready", 32'(rdy_s[2]), 32'd0);
            check("sel_oor_valid", 32'(ov[2]), 32'd0);
        end

        // Round-robin with all valid, then only channels 1 and 3.
        do_reset();
        t_valid[1] = 4'hF;
        t_last[1]  = 4'hF;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("rr_all_%0d", i), 32'(oc[1]), 32'(exp4a[i]));
        end
        do_reset();
        t_valid[1] = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rr_odd_%0d", i), 32'(oc[1]), 32'(exp4b[i]));
        end

        // Channel 0 sends a 3-beat packet while channel 1 stays valid.
        do_reset();
        cnt = 0;
        nb  = 0;
        for (int i = 0; i < 5; i++) begin
            t_valid[1] = {2'b00, 1'b1, cnt < 3};
            t_last[1]  = {2'b11, 1'b1, cnt == 2};
            step();
            if (rdy_s[1][0]) cnt++;
            if (ov[1]) begin
                check($sformatf("pkt_%0d", nb), 32'(oc[1]), 32'(exp6[nb]));
                nb++;
            end
        end
        check("pkt_beats", 32'(nb), 32'd5);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < 3; k++) begin
                t_data[k]  = $urandom;
                t_valid[k] = 4'($urandom);
                t_last[k]  = 4'($urandom) | 4'($urandom);
                t_sel[k]   = 2'($urandom);
                t_ordy[k]  = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
